// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : single-issue instruction fetch / issue / retire sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              halt_req_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_rd_en_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              exec_done_i,
  input  logic              jump_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              addr_err_o,
  output logic [31:0]       retired_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  // One extra bit so a depth of exactly 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(MEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [31:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] next_pc;
  logic              next_oob;

  assign next_pc  = jump_i         ? jump_target_i   :
                    branch_taken_i ? branch_target_i :
                                     pc_q + ADDR_W'(1);
  assign next_oob = ({1'b0, next_pc} >= DEPTH_C);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = err_q;
    retired_d = retired_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          state_d   = FETCH;
          pc_d      = RESET_PC_C;
          retired_d = '0;
          err_d     = 1'b0;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        instr_d = imem_rdata_i;
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (valid_q && instr_ready_i) begin
          valid_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done_i) begin
          retired_d = retired_q + 32'd1;
          // An out-of-range target wins over halt_req and leaves pc on the faulting instruction.
          if (next_oob) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = halt_req_i ? HALT : FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC_C;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign imem_rd_en_o  = (state_q == FETCH);
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign busy_o        = (state_q != IDLE) && (state_q != HALT);
  assign addr_err_o    = err_q;
  assign retired_o     = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed table-driven bench for fetch_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, instr_ready, exec_done, jump, branch_taken;
  logic [15:0] jump_target, branch_target;
  logic [15:0] imem_addr, pc;
  logic        imem_rd_en, instr_valid, busy, addr_err;
  logic [31:0] imem_rdata, instr, retired;

  logic [31:0] mem [256];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_pc;
  logic [31:0] exp_retired;

  typedef struct {
    logic        restart;
    logic        jump;
    logic [15:0] jt;
    logic        br;
    logic [15:0] bt;
    logic        halt;
    logic [15:0] exp_pc;
    logic        exp_halted;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  fetch_sequencer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .halt_req_i      (halt_req),
    .imem_addr_o     (imem_addr),
    .imem_rd_en_o    (imem_rd_en),
    .imem_rdata_i    (imem_rdata),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .exec_done_i     (exec_done),
    .jump_i          (jump),
    .branch_taken_i  (branch_taken),
    .jump_target_i   (jump_target),
    .branch_target_i (branch_target),
    .pc_o            (pc),
    .busy_o          (busy),
    .addr_err_o      (addr_err),
    .retired_o       (retired)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt_req = 1'b0; instr_ready = 1'b0; exec_done = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; jump_target = '0; branch_target = '0;
  endtask

  // Entered at a falling edge in FETCH (or IDLE/HALT when restart is set).
  task automatic run_row(input int idx, input vec_t v);
    if (v.restart) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_pc = 16'h0000;
      exp_retired = 32'd0;
    end
    chk($sformatf("r%0d_fetch_rd_en", idx), 32'(imem_rd_en), 32'd1);
    chk($sformatf("r%0d_fetch_addr", idx), 32'(imem_addr), 32'(exp_pc));
    chk($sformatf("r%0d_fetch_retired", idx), retired, exp_retired);
    @(negedge clk);
    chk($sformatf("r%0d_latch_valid", idx), 32'(instr_valid), 32'd0);
    chk($sformatf("r%0d_latch_rd_en", idx), 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    chk($sformatf("r%0d_issue_valid", idx), 32'(instr_valid), 32'd1);
    chk($sformatf("r%0d_issue_instr", idx), instr, mem[exp_pc[7:0]]);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk($sformatf("r%0d_exec_valid", idx), 32'(instr_valid), 32'd0);
    chk($sformatf("r%0d_exec_busy", idx), 32'(busy), 32'd1);
    exec_done = 1'b1; jump = v.jump; jump_target = v.jt;
    branch_taken = v.br; branch_target = v.bt; halt_req = v.halt;
    @(negedge clk);
    clear_inputs();
    exp_retired = exp_retired + 32'd1;
    exp_pc = v.exp_pc;
    chk($sformatf("r%0d_pc", idx), 32'(pc), 32'(exp_pc));
    chk($sformatf("r%0d_busy", idx), 32'(busy), 32'(!v.exp_halted));
    chk($sformatf("r%0d_addr_err", idx), 32'(addr_err), 32'(v.exp_err));
    chk($sformatf("r%0d_retired", idx), retired, exp_retired);
    chk($sformatf("r%0d_next_rd_en", idx), 32'(imem_rd_en), 32'(!v.exp_halted));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    mem[0] = 32'h8C01_0020;

    //            restart jump jt        br  bt        halt exp_pc    halted err
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0020, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h00FF, 1'b0, 16'h0000, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00FF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h00FE, 1'b0, 16'h00FE, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b1};

    clear_inputs();
    rst_n = 1'b0;
    exp_pc = 16'h0000;
    exp_retired = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_retired", retired, 32'd0);

    for (int i = 0; i < 10; i++) run_row(i, vecs[i]);

    // Stall in ISSUE with stray exec_done/start and an early halt_req.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    halt_req = 1'b1;
    chk("hs_fetch_pc", 32'(pc), 32'd0);
    chk("hs_fetch_retired", retired, 32'd0);
    chk("hs_fetch_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    chk("hs_latch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hs_stall_valid", 32'(instr_valid), 32'd1);
      chk("hs_stall_instr", instr, 32'h8C01_0020);
      chk("hs_stall_pc", 32'(pc), 32'd0);
      exec_done = (i == 1);
      start = (i == 2);
      @(negedge clk);
    end
    exec_done = 1'b0;
    start = 1'b0;
    chk("hs_still_issue", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("hs_exec_valid", 32'(instr_valid), 32'd0);
    chk("hs_exec_retired", retired, 32'd0);
    exec_done = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk("hs_halt_busy", 32'(busy), 32'd0);
    chk("hs_halt_pc", 32'(pc), 32'd1);
    chk("hs_halt_retired", retired, 32'd1);
    chk("hs_halt_rd_en", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    chk("hs_halt_hold_busy", 32'(busy), 32'd0);
    chk("hs_halt_hold_pc", 32'(pc), 32'd1);

    // Restart, retire one jump to 5, then reset asynchronously mid-EXEC.
    exp_pc = 16'h0000;
    exp_retired = 32'd0;
    run_row(10, '{1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    chk("ar_issue_instr", instr, mem[5]);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("ar_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_state_busy", 32'(busy), 32'd0);
    chk("ar_pc", 32'(pc), 32'd0);
    chk("ar_instr", instr, 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_rd_en", 32'(imem_rd_en), 32'd0);
    chk("ar_err", 32'(addr_err), 32'd0);
    chk("ar_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_idle_busy", 32'(busy), 32'd0);
    chk("ar_idle_valid", 32'(instr_valid), 32'd0);
    chk("ar_idle_rd_en", 32'(imem_rd_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, instruction-memory word-address width.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter MEM_DEPTH, default 256, number of valid instruction words.
REQ-004 Parameter RESET_PC, default 0, PC loaded at reset and on start.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins fetching from RESET_PC when in IDLE or HALT.
REQ-008 halt_req  in  1  level; stop after the current instruction retires.
REQ-009 imem_addr  out  ADDR_W  word address to instruction memory.
REQ-010 imem_rd_en  out  1  read strobe, high only in FETCH.
REQ-011 imem_rdata  in  DATA_W  instruction word, valid on the cycle after imem_rd_en.
REQ-012 instr  out  DATA_W  latched instruction presented to execute.
REQ-013 instr_valid  out  1  instr valid, held until accepted.
REQ-014 instr_ready  in  1  execute accepts instr when high with instr_valid.
REQ-015 exec_done  in  1  one-cycle pulse; the issued instruction has completed.
REQ-016 jump, branch_taken  in  1 each  redirect qualifiers, sampled only with exec_done.
REQ-017 jump_target, branch_target  in  ADDR_W each  redirect word addresses.
REQ-018 pc  out  ADDR_W  address of the instruction in flight.
REQ-019 busy  out  1  high in any state other than IDLE and HALT.
REQ-020 addr_err  out  1  sticky; next PC was >= MEM_DEPTH.
REQ-021 retired  out  32  count of instructions completed since reset or start.

Function
REQ-022 FSM states: IDLE, FETCH, LATCH, ISSUE, EXEC, HALT.
REQ-023 IDLE: outputs quiescent; start -> FETCH with pc=RESET_PC, retired=0, addr_err=0.
REQ-024 FETCH, one cycle: imem_addr=pc, imem_rd_en=1; -> LATCH.
REQ-025 LATCH, one cycle: instr<=imem_rdata; -> ISSUE with instr_valid=1 on the next cycle.
REQ-026 ISSUE: hold instr and instr_valid stable; instr_valid&&instr_ready -> EXEC, instr_valid drops next cycle.
REQ-027 EXEC: wait for exec_done; an exec_done outside EXEC is ignored.
REQ-028 On exec_done, retired increments by 1, wrapping modulo 2^32.
REQ-029 On exec_done, next pc priority: jump -> jump_target; else branch_taken -> branch_target; else pc+1, modulo 2^ADDR_W.
REQ-030 If next pc >= MEM_DEPTH: addr_err<=1, pc unchanged, -> HALT.
REQ-031 Else if halt_req is high on the exec_done cycle: pc<=next pc, -> HALT.
REQ-032 Otherwise: pc<=next pc, -> FETCH.
REQ-033 halt_req in FETCH, LATCH, ISSUE or EXEC does not abort; it takes effect only per REQ-031.
REQ-034 HALT: busy=0, pc and retired held; start restarts per REQ-023.
REQ-035 start is ignored while busy.
REQ-036 Minimum fetch-to-issue latency: instr_valid asserts 2 cycles after the FETCH cycle.
REQ-037 imem_addr = pc in all states; imem_rd_en = 0 outside FETCH.

Reset
REQ-038 rst_n low forces, asynchronously: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_rd_en=0, busy=0, addr_err=0, retired=0.
REQ-039 Reset deassertion mid-operation resumes in IDLE; no partial instruction is re-issued.

Verification
REQ-040 Memory word0=0x8C010020; pulse start, ready=1, exec_done 1 cycle after accept -> rd_en at addr 0, instr=0x8C010020, retired=1, pc=1.
REQ-041 instr_ready held low 5 cycles in ISSUE -> instr and instr_valid stable throughout; exactly one accept.
REQ-042 exec_done with jump=1 to 0x0010 and branch_taken=1 to 0x0020 -> next FETCH at 0x0010.
REQ-043 pc=255, MEM_DEPTH=256, exec_done with no redirect -> addr_err=1, state HALT, pc=255.
REQ-044 halt_req raised in ISSUE -> instruction completes, retired increments, HALT with busy=0; start restarts at RESET_PC with retired=0.
REQ-045 rst_n pulsed low in EXEC -> all outputs at REQ-038 values immediately, before the next clock edge.
